// File: rtl/bit_serializer.sv
`timescale 1ns/1ps
// bit_serializer
//   Parallel-to-serial front end for the serial sequence detector. WIDTH-bit
//   words arrive over a valid/ready handshake, are buffered in a DEPTH-entry
//   FIFO and are shifted out one bit per clock on dout. Between words the line
//   sits at IDLE_BIT, optionally with IDLE_GAP idle cycles after every word.
//
// Ports
//   clk        in   clock, all state on posedge
//   rst_n      in   asynchronous active-low reset
//   data_in    in   word to serialize
//   data_valid in   data_in valid
//   data_ready out  FIFO can accept a word (count < DEPTH, and not in reset)
//   dout       out  registered serial bit (detector din)
//   dout_valid out  dout carries a data bit rather than idle/gap
//   word_done  out  high while the last bit of a word is on dout
//   fifo_count out  registered FIFO occupancy
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1,
  parameter int unsigned IDLE_GAP  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic                       dout,
  output logic                       dout_valid,
  output logic                       word_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [7:0]  GAP_INIT = 8'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  // FIFO
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Shifter / FSM
  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             do_load;
  logic [WIDTH-1:0] head;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign data_ready = (count_q < CW'(DEPTH)) && rst_n;
  assign push       = data_valid && data_ready;
  assign count_d    = count_q + CW'(push) - CW'(pop);
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Loading a word puts its first bit on dout in the same edge that pops it;
  // shreg then holds only the bits still to be sent.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    dout_d       = IDLE_BIT;
    dout_valid_d = 1'b0;
    do_load      = 1'b0;
    pop          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) do_load = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt_q != '0) begin
          dout_d       = first_bit(shreg_q);
          dout_valid_d = 1'b1;
          shreg_d      = shift_word(shreg_q);
          bit_cnt_d    = bit_cnt_q - BW'(1);
        end else if (IDLE_GAP == 0 && count_q != '0) begin
          do_load = 1'b1;
        end else if (IDLE_GAP > 0) begin
          state_d   = GAP;
          gap_cnt_d = GAP_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        // The last gap cycle doubles as the IDLE check so the gap is exact.
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end else if (count_q != '0) begin
          do_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      pop          = 1'b1;
      shreg_d      = shift_word(head);
      dout_d       = first_bit(head);
      dout_valid_d = 1'b1;
      bit_cnt_d    = BW'(WIDTH - 1);
      state_d      = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign word_done  = (state_q == SHIFT) && (bit_cnt_q == '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_bit_serializer.sv
`timescale 1ns/1ps
module tb_bit_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;

  // main: MSB first, no gap; lsb: LSB first; gap: IDLE_GAP=2
  logic       rdy_m, dout_m, dv_m, wd_m;
  logic [2:0] cnt_m;
  logic       rdy_l, dout_l, dv_l, wd_l;
  logic [2:0] cnt_l;
  logic       rdy_g, dout_g, dv_g, wd_g;
  logic [2:0] cnt_g;

  int checks   = 0;
  int failures = 0;

  bit         q[$];
  logic [7:0] window;
  int         hits;

  bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .IDLE_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_m), .dout(dout_m), .dout_valid(dv_m), .word_done(wd_m), .fifo_count(cnt_m));

  bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .IDLE_GAP(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_l), .dout(dout_l), .dout_valid(dv_l), .word_done(wd_l), .fifo_count(cnt_l));

  bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .IDLE_GAP(2)) dut_g (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_g), .dout(dout_g), .dout_valid(dv_g), .word_done(wd_g), .fifo_count(cnt_g));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream capture and a simple 8'hAA detector on the main DUT's valid bits.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      window <= '0;
      hits   <= 0;
    end else if (dv_m) begin
      q.push_back(dout_m);
      window <= {window[6:0], dout_m};
      if ({window[6:0], dout_m} == 8'hAA) hits <= hits + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    data_valid = 1'b1;
    data_in    = 8'hFF;
    repeat (3) tick();
    checks++; if (dout_m !== 1'b1) begin failures++; $display("FAIL reset_dout got=%b exp=1", dout_m); end
    checks++; if (dv_m !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b exp=0", dv_m); end
    checks++; if (wd_m !== 1'b0) begin failures++; $display("FAIL reset_word_done got=%b exp=0", wd_m); end
    checks++; if (cnt_m !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt_m); end
    checks++; if ({rdy_m, rdy_l, rdy_g} !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", {rdy_m, rdy_l, rdy_g}); end
    checks++; if ({dout_l, dout_g, dv_l, dv_g, wd_l, wd_g} !== 6'b110000) begin failures++; $display("FAIL reset_other_duts got=%b exp=110000", {dout_l, dout_g, dv_l, dv_g, wd_l, wd_g}); end
    checks++; if ({cnt_l, cnt_g} !== 6'd0) begin failures++; $display("FAIL reset_other_counts got=%b exp=0", {cnt_l, cnt_g}); end
    data_valid = 1'b0;
    rst_n      = 1'b1;
    #1;
    checks++; if ({rdy_m, rdy_l, rdy_g} !== 3'b111) begin failures++; $display("FAIL release_ready got=%b exp=111", {rdy_m, rdy_l, rdy_g}); end
    tick();
    checks++; if (cnt_m !== 3'd0 || dv_m !== 1'b0) begin failures++; $display("FAIL release_idle cnt=%0d dv=%b exp cnt=0 dv=0", cnt_m, dv_m); end
  endtask

  task automatic test_single_word;
    logic [7:0] w;
    w = 8'hAA;
    do_reset();
    data_valid = 1'b1;
    data_in    = w;
    tick();
    data_valid = 1'b0;
    checks++; if (cnt_m !== 3'd1 || dv_m !== 1'b0) begin failures++; $display("FAIL single_push cnt=%0d dv=%b exp cnt=1 dv=0", cnt_m, dv_m); end
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (dout_m !== w[8-c] || dv_m !== 1'b1 || wd_m !== (c == 8)) begin
        failures++;
        $display("FAIL single_msb cycle=%0d got dout=%b dv=%b wd=%b exp dout=%b dv=1 wd=%b", c, dout_m, dv_m, wd_m, w[8-c], (c == 8));
      end
      checks++;
      if (dout_l !== w[c-1] || dv_l !== 1'b1 || wd_l !== (c == 8)) begin
        failures++;
        $display("FAIL single_lsb cycle=%0d got dout=%b dv=%b wd=%b exp dout=%b dv=1 wd=%b", c, dout_l, dv_l, wd_l, w[c-1], (c == 8));
      end
    end
    for (int c = 9; c <= 11; c++) begin
      tick();
      checks++;
      if (dout_m !== 1'b1 || dv_m !== 1'b0 || wd_m !== 1'b0 || cnt_m !== 3'd0) begin
        failures++;
        $display("FAIL single_after cycle=%0d got dout=%b dv=%b wd=%b cnt=%0d exp 1 0 0 0", c, dout_m, dv_m, wd_m, cnt_m);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s;
    logic        e_d, e_v, e_w, g_d, g_v, g_w;
    s = 16'h55F0;
    do_reset();
    data_valid = 1'b1;
    data_in    = 8'h55;
    tick();
    data_in = 8'hF0;
    tick();
    data_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) tick();
      e_v = (c <= 16);
      e_d = (c <= 16) ? s[16-c] : 1'b1;
      e_w = (c == 8) || (c == 16);
      g_v = (c <= 8) || (c >= 11 && c <= 18);
      g_d = (c <= 8) ? s[16-c] : ((c >= 11 && c <= 18) ? s[18-c] : 1'b1);
      g_w = (c == 8) || (c == 18);
      checks++;
      if (dout_m !== e_d || dv_m !== e_v || wd_m !== e_w) begin
        failures++;
        $display("FAIL b2b_nogap cycle=%0d got dout=%b dv=%b wd=%b exp dout=%b dv=%b wd=%b", c, dout_m, dv_m, wd_m, e_d, e_v, e_w);
      end
      checks++;
      if (dout_g !== g_d || dv_g !== g_v || wd_g !== g_w) begin
        failures++;
        $display("FAIL b2b_gap2 cycle=%0d got dout=%b dv=%b wd=%b exp dout=%b dv=%b wd=%b", c, dout_g, dv_g, wd_g, g_d, g_v, g_w);
      end
    end
    checks++; if (cnt_g !== 3'd0) begin failures++; $display("FAIL b2b_gap_count got=%0d exp=0", cnt_g); end
  endtask

  task automatic test_full_fifo;
    logic [7:0]  w [6];
    logic [47:0] exp48;
    int          errs;
    w = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7, 8'h3C};
    exp48 = {w[0], w[1], w[2], w[3], w[4], w[5]};
    do_reset();
    data_valid = 1'b1;
    data_in    = w[0];
    tick();
    data_valid = 1'b0;
    tick();
    checks++; if (dv_m !== 1'b1 || cnt_m !== 3'd0) begin failures++; $display("FAIL full_busy dv=%b cnt=%0d exp dv=1 cnt=0", dv_m, cnt_m); end
    for (int i = 1; i <= 4; i++) begin
      data_valid = 1'b1;
      data_in    = w[i];
      tick();
    end
    checks++; if (cnt_m !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", cnt_m); end
    checks++; if (rdy_m !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", rdy_m); end
    data_in = w[5];
    tick();
    checks++; if (cnt_m !== 3'd4 || rdy_m !== 1'b0) begin failures++; $display("FAIL full_reject cnt=%0d rdy=%b exp cnt=4 rdy=0", cnt_m, rdy_m); end
    repeat (2) tick();
    checks++; if (wd_m !== 1'b1) begin failures++; $display("FAIL full_first_done got=%b exp=1", wd_m); end
    tick();
    checks++; if (cnt_m !== 3'd3 || rdy_m !== 1'b1) begin failures++; $display("FAIL full_pop cnt=%0d rdy=%b exp cnt=3 rdy=1", cnt_m, rdy_m); end
    tick();
    data_valid = 1'b0;
    checks++; if (cnt_m !== 3'd4 || rdy_m !== 1'b0) begin failures++; $display("FAIL full_accept_held cnt=%0d rdy=%b exp cnt=4 rdy=0", cnt_m, rdy_m); end
    repeat (45) tick();
    errs = 0;
    if (q.size() != 48) errs = 1;
    else for (int i = 0; i < 48; i++) if (q[i] != exp48[47-i]) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL full_stream size=%0d bit_errors=%0d exp size=48 bit_errors=0", q.size(), errs); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    data_valid = 1'b1;
    data_in    = 8'hC3;
    tick();
    data_valid = 1'b0;
    repeat (3) tick();
    checks++; if (dout_m !== 1'b0 || dv_m !== 1'b1) begin failures++; $display("FAIL midrst_third_bit dout=%b dv=%b exp dout=0 dv=1", dout_m, dv_m); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dout_m !== 1'b1 || dv_m !== 1'b0 || cnt_m !== 3'd0 || rdy_m !== 1'b0 || wd_m !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async dout=%b dv=%b cnt=%0d rdy=%b wd=%b exp 1 0 0 0 0", dout_m, dv_m, cnt_m, rdy_m, wd_m);
    end
    #2 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (dout_m !== 1'b1 || dv_m !== 1'b0 || cnt_m !== 3'd0) begin
        failures++;
        $display("FAIL midrst_no_resume cycle=%0d dout=%b dv=%b cnt=%0d exp 1 0 0", c, dout_m, dv_m, cnt_m);
      end
    end
  endtask

  task automatic test_end_to_end;
    do_reset();
    repeat (3) tick();
    data_valid = 1'b1;
    data_in    = 8'b1010_1010;
    tick();
    data_in = 8'h00;
    tick();
    data_valid = 1'b0;
    repeat (22) tick();
    checks++; if (hits !== 1) begin failures++; $display("FAIL e2e_detect hits=%0d exp=1", hits); end
    checks++; if (q.size() != 16) begin failures++; $display("FAIL e2e_valid_bits got=%0d exp=16", q.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_full_fifo();
    test_mid_reset();
    test_end_to_end();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
